// File: rtl/cache_pkg.sv
// Shared parameters, FSM encoding and cache line layout
// for the 4-way write-back cache controller.
package cache_pkg;

    localparam int WORD_SIZE        = 32;
    localparam int BLOCK_OFFSET     = 4;
    localparam int SETS             = 128;
    localparam int SETS_BITS        = $clog2(SETS);
    localparam int AGE_BITS         = 2;
    localparam int TAG_BITS         = WORD_SIZE - SETS_BITS - BLOCK_OFFSET;
    localparam int BLOCK_DATA_WIDTH = WORD_SIZE << BLOCK_OFFSET;
    localparam int DIRTY_BIT        = 1;
    localparam int VALID_BIT        = 1;
    localparam int BANK             = 4;

    localparam int LINE_W = VALID_BIT + DIRTY_BIT + AGE_BITS
                          + TAG_BITS + BLOCK_DATA_WIDTH;

    localparam int VALID_IDX = LINE_W - 1;
    localparam int DIRTY_IDX = LINE_W - 2;
    localparam int AGE_HI    = LINE_W - 3;
    localparam int AGE_LO    = AGE_HI - AGE_BITS + 1;
    localparam int TAG_HI    = AGE_LO - 1;
    localparam int TAG_LO    = BLOCK_DATA_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE          = 3'd0,
        ST_CHECK_HIT     = 3'd1,
        ST_EVICT         = 3'd2,
        ST_ALLOCATE      = 3'd3,
        ST_SEND_TO_CACHE = 3'd4
    } state_e;

    typedef struct packed {
        logic                        valid;
        logic                        dirty;
        logic [AGE_BITS-1:0]         age;
        logic [TAG_BITS-1:0]         tag;
        logic [BLOCK_DATA_WIDTH-1:0] data;
    } line_t;

    function automatic logic [BLOCK_DATA_WIDTH-1:0] put_word(
        input logic [BLOCK_DATA_WIDTH-1:0] data,
        input logic [BLOCK_OFFSET-1:0]     idx,
        input logic [WORD_SIZE-1:0]        word
    );
        logic [BLOCK_DATA_WIDTH-1:0] r;
        r = data;
        r[idx*WORD_SIZE +: WORD_SIZE] = word;
        return r;
    endfunction

    function automatic logic [WORD_SIZE-1:0] get_word(
        input logic [BLOCK_DATA_WIDTH-1:0] data,
        input logic [BLOCK_OFFSET-1:0]     idx
    );
        return data[idx*WORD_SIZE +: WORD_SIZE];
    endfunction

endpackage

// File: rtl/cache_controller_lru_victim_sel.sv
// Combinational way match, victim choice and LRU age update
// for the four candidate ways of one set.
module lru_victim_sel
    import cache_pkg::*;
(
    input  logic [LINE_W-1:0]        i_cand_1,
    input  logic [LINE_W-1:0]        i_cand_2,
    input  logic [LINE_W-1:0]        i_cand_3,
    input  logic [LINE_W-1:0]        i_cand_4,
    input  logic [TAG_BITS-1:0]      i_tag,
    output logic                     o_hit,
    output logic [1:0]               o_tgt_idx,
    output logic [LINE_W-1:0]        o_tgt_line,
    output logic [BANK*AGE_BITS-1:0] o_ages
);

    line_t               w_c [BANK];
    logic [BANK-1:0]     w_match;
    logic [BANK-1:0]     w_invalid;
    logic [1:0]          w_hit_idx;
    logic [1:0]          w_inv_idx;
    logic [1:0]          w_max_idx;
    logic [AGE_BITS-1:0] w_max_age;
    logic [AGE_BITS-1:0] w_old_age;
    logic                w_any_inv;

    assign w_c[0] = i_cand_1;
    assign w_c[1] = i_cand_2;
    assign w_c[2] = i_cand_3;
    assign w_c[3] = i_cand_4;

    always_comb begin
        w_match   = '0;
        w_invalid = '0;
        for (int i = 0; i < BANK; i++) begin
            w_match[i]   = w_c[i].valid && (w_c[i].tag == i_tag);
            w_invalid[i] = !w_c[i].valid;
        end
    end

    // Downward scans so the lowest-numbered way wins.
    always_comb begin
        w_hit_idx = 2'd0;
        w_inv_idx = 2'd0;
        for (int i = BANK - 1; i >= 0; i--) begin
            if (w_match[i])   w_hit_idx = 2'(i);
            if (w_invalid[i]) w_inv_idx = 2'(i);
        end
    end

    always_comb begin
        w_max_age = w_c[0].age;
        w_max_idx = 2'd0;
        for (int i = 1; i < BANK; i++) begin
            if (w_c[i].age > w_max_age) begin
                w_max_age = w_c[i].age;
                w_max_idx = 2'(i);
            end
        end
    end

    assign o_hit     = |w_match;
    assign w_any_inv = |w_invalid;
    assign o_tgt_idx = o_hit ? w_hit_idx
                     : (w_any_inv ? w_inv_idx : w_max_idx);
    assign o_tgt_line = w_c[o_tgt_idx];

    // A fill into an empty way ages every other way.
    assign w_old_age = (!o_hit && w_any_inv) ? {AGE_BITS{1'b1}}
                                             : w_c[o_tgt_idx].age;

    always_comb begin
        o_ages = '0;
        for (int i = 0; i < BANK; i++) begin
            if (2'(i) == o_tgt_idx)
                o_ages[i*AGE_BITS +: AGE_BITS] = '0;
            else if (w_c[i].age < w_old_age)
                o_ages[i*AGE_BITS +: AGE_BITS] = w_c[i].age + 1'b1;
            else
                o_ages[i*AGE_BITS +: AGE_BITS] = w_c[i].age;
        end
    end

endmodule

// File: rtl/cache_controller.sv
// FSM controller for a 4-way set-associative write-back,
// write-allocate cache with LRU replacement.
module cache_controller
    import cache_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [WORD_SIZE-1:0]        cpu_req_addr,
    input  logic [WORD_SIZE-1:0]        cpu_req_datain,
    input  logic                        cpu_req_rw,
    input  logic                        cpu_req_enable,
    output logic [WORD_SIZE-1:0]        cpu_res_dataout,
    output logic                        cpu_res_ready,
    output logic [WORD_SIZE-1:0]        mem_req_addr,
    output logic [BLOCK_DATA_WIDTH-1:0] mem_req_dataout,
    output logic                        mem_req_rw,
    output logic                        mem_req_enable,
    input  logic                        mem_req_ready,
    input  logic [BLOCK_DATA_WIDTH-1:0] mem_req_datain,
    output logic                        cache_enable,
    output logic                        cache_rw,
    input  logic                        cache_ready,
    input  logic [LINE_W-1:0]           candidate_1,
    input  logic [LINE_W-1:0]           candidate_2,
    input  logic [LINE_W-1:0]           candidate_3,
    input  logic [LINE_W-1:0]           candidate_4,
    output logic [AGE_BITS-1:0]         age_1,
    output logic [AGE_BITS-1:0]         age_2,
    output logic [AGE_BITS-1:0]         age_3,
    output logic [AGE_BITS-1:0]         age_4,
    output logic [LINE_W-1:0]           candidate_write,
    output logic [BANK-1:0]             bank_selector
);

    localparam logic [2:0] IDLE          = ST_IDLE;
    localparam logic [2:0] CHECK_HIT     = ST_CHECK_HIT;
    localparam logic [2:0] EVICT         = ST_EVICT;
    localparam logic [2:0] ALLOCATE      = ST_ALLOCATE;
    localparam logic [2:0] SEND_TO_CACHE = ST_SEND_TO_CACHE;

    logic [2:0]                  current_state;
    logic [2:0]                  w_next_state;
    logic                        hit;
    logic                        miss;

    logic [WORD_SIZE-1:0]        r_addr;
    logic                        r_rw;
    logic [WORD_SIZE-1:0]        r_din;
    line_t                       r_line;
    logic [BANK-1:0]             r_way;
    logic [BANK*AGE_BITS-1:0]    r_ages;
    logic [WORD_SIZE-1:0]        r_evict_addr;
    logic [BLOCK_DATA_WIDTH-1:0] r_evict_data;
    logic [WORD_SIZE-1:0]        r_dout;
    logic                        r_res_ready;

    logic [TAG_BITS-1:0]         w_tag;
    logic [SETS_BITS-1:0]        w_set;
    logic [BLOCK_OFFSET-1:0]     w_word;
    logic                        w_hit;
    logic [1:0]                  w_tgt_idx;
    logic [LINE_W-1:0]           w_tgt_raw;
    line_t                       w_tgt;
    logic [BANK*AGE_BITS-1:0]    w_ages;
    line_t                       w_hit_line;
    line_t                       w_fill_line;
    logic                        w_tag_done;

    assign w_tag  = r_addr[WORD_SIZE-1 -: TAG_BITS];
    assign w_set  = r_addr[BLOCK_OFFSET +: SETS_BITS];
    assign w_word = r_addr[BLOCK_OFFSET-1:0];

    lru_victim_sel u_sel (
        .i_cand_1   (candidate_1),
        .i_cand_2   (candidate_2),
        .i_cand_3   (candidate_3),
        .i_cand_4   (candidate_4),
        .i_tag      (w_tag),
        .o_hit      (w_hit),
        .o_tgt_idx  (w_tgt_idx),
        .o_tgt_line (w_tgt_raw),
        .o_ages     (w_ages)
    );

    assign w_tgt      = w_tgt_raw;
    assign w_tag_done = (current_state == CHECK_HIT) && cache_ready;
    assign hit        = w_tag_done && w_hit;
    assign miss       = w_tag_done && !w_hit;

    always_comb begin
        w_hit_line     = w_tgt;
        w_hit_line.age = '0;
        if (r_rw) begin
            w_hit_line.dirty = 1'b1;
            w_hit_line.data  = put_word(w_tgt.data, w_word, r_din);
        end
    end

    always_comb begin
        w_fill_line.valid = 1'b1;
        w_fill_line.dirty = r_rw;
        w_fill_line.age   = '0;
        w_fill_line.tag   = w_tag;
        w_fill_line.data  = r_rw ? put_word(mem_req_datain, w_word, r_din)
                                 : mem_req_datain;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) current_state <= IDLE;
        else        current_state <= w_next_state;
    end

    always_comb begin
        w_next_state = current_state;
        case (current_state)
            IDLE:
                if (cpu_req_enable) w_next_state = CHECK_HIT;
            CHECK_HIT:
                if (cache_ready) begin
                    if (w_hit)
                        w_next_state = SEND_TO_CACHE;
                    else if (w_tgt.valid && w_tgt.dirty)
                        w_next_state = EVICT;
                    else
                        w_next_state = ALLOCATE;
                end
            EVICT:
                if (mem_req_ready) w_next_state = ALLOCATE;
            ALLOCATE:
                if (mem_req_ready) w_next_state = SEND_TO_CACHE;
            SEND_TO_CACHE:
                if (cache_ready) w_next_state = IDLE;
            default:
                w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= '0;
            r_rw         <= 1'b0;
            r_din        <= '0;
            r_line       <= '0;
            r_way        <= '0;
            r_ages       <= '0;
            r_evict_addr <= '0;
            r_evict_data <= '0;
            r_dout       <= '0;
            r_res_ready  <= 1'b0;
        end else begin
            r_res_ready <= 1'b0;
            case (current_state)
                IDLE:
                    if (cpu_req_enable) begin
                        r_addr <= cpu_req_addr;
                        r_rw   <= cpu_req_rw;
                        r_din  <= cpu_req_datain;
                    end
                CHECK_HIT:
                    if (cache_ready) begin
                        r_way        <= BANK'(1) << w_tgt_idx;
                        r_ages       <= w_ages;
                        r_evict_addr <= {w_tgt.tag, w_set,
                                         {BLOCK_OFFSET{1'b0}}};
                        r_evict_data <= w_tgt.data;
                        if (w_hit) begin
                            r_line <= w_hit_line;
                            if (!r_rw)
                                r_dout <= get_word(w_tgt.data, w_word);
                        end
                    end
                ALLOCATE:
                    if (mem_req_ready) begin
                        r_line <= w_fill_line;
                        if (!r_rw)
                            r_dout <= get_word(mem_req_datain, w_word);
                    end
                SEND_TO_CACHE:
                    if (cache_ready) r_res_ready <= 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        cpu_res_dataout = r_dout;
        cpu_res_ready   = r_res_ready;
        mem_req_addr    = '0;
        mem_req_dataout = '0;
        mem_req_rw      = 1'b0;
        mem_req_enable  = 1'b0;
        cache_enable    = 1'b0;
        cache_rw        = 1'b0;
        candidate_write = '0;
        bank_selector   = '0;
        age_1           = '0;
        age_2           = '0;
        age_3           = '0;
        age_4           = '0;
        case (current_state)
            IDLE:
                cache_enable = cpu_req_enable && rst_n;
            CHECK_HIT:
                cache_enable = 1'b1;
            EVICT: begin
                mem_req_enable  = 1'b1;
                mem_req_rw      = 1'b1;
                mem_req_addr    = r_evict_addr;
                mem_req_dataout = r_evict_data;
            end
            ALLOCATE: begin
                mem_req_enable = 1'b1;
                mem_req_addr   = {w_tag, w_set, {BLOCK_OFFSET{1'b0}}};
            end
            SEND_TO_CACHE: begin
                cache_enable    = 1'b1;
                cache_rw        = 1'b1;
                candidate_write = r_line;
                bank_selector   = r_way;
                age_1           = r_ages[0*AGE_BITS +: AGE_BITS];
                age_2           = r_ages[1*AGE_BITS +: AGE_BITS];
                age_3           = r_ages[2*AGE_BITS +: AGE_BITS];
                age_4           = r_ages[3*AGE_BITS +: AGE_BITS];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_controller.sv
// Directed scoreboard bench for cache_controller: array and
// memory are modelled by the bench driving ready strobes.
module tb_cache_controller;

    localparam int LW = 537;

    logic           clk;
    logic           rst_n;
    logic [31:0]    cpu_req_addr;
    logic [31:0]    cpu_req_datain;
    logic           cpu_req_rw;
    logic           cpu_req_enable;
    logic [31:0]    cpu_res_dataout;
    logic           cpu_res_ready;
    logic [31:0]    mem_req_addr;
    logic [511:0]   mem_req_dataout;
    logic           mem_req_rw;
    logic           mem_req_enable;
    logic           mem_req_ready;
    logic [511:0]   mem_req_datain;
    logic           cache_enable;
    logic           cache_rw;
    logic           cache_ready;
    logic [LW-1:0]  candidate_1;
    logic [LW-1:0]  candidate_2;
    logic [LW-1:0]  candidate_3;
    logic [LW-1:0]  candidate_4;
    logic [1:0]     age_1;
    logic [1:0]     age_2;
    logic [1:0]     age_3;
    logic [1:0]     age_4;
    logic [LW-1:0]  candidate_write;
    logic [3:0]     bank_selector;

    int n_tests;
    int n_fail;

    typedef struct {
        logic          hit;
        logic          evict;
        logic [31:0]   ev_addr;
        logic [511:0]  ev_data;
        logic [31:0]   al_addr;
        logic [3:0]    bank;
        logic [LW-1:0] line;
        logic [7:0]    ages;
        logic [31:0]   dout;
    } exp_t;

    exp_t sb[$];

    cache_controller dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cpu_req_addr    (cpu_req_addr),
        .cpu_req_datain  (cpu_req_datain),
        .cpu_req_rw      (cpu_req_rw),
        .cpu_req_enable  (cpu_req_enable),
        .cpu_res_dataout (cpu_res_dataout),
        .cpu_res_ready   (cpu_res_ready),
        .mem_req_addr    (mem_req_addr),
        .mem_req_dataout (mem_req_dataout),
        .mem_req_rw      (mem_req_rw),
        .mem_req_enable  (mem_req_enable),
        .mem_req_ready   (mem_req_ready),
        .mem_req_datain  (mem_req_datain),
        .cache_enable    (cache_enable),
        .cache_rw        (cache_rw),
        .cache_ready     (cache_ready),
        .candidate_1     (candidate_1),
        .candidate_2     (candidate_2),
        .candidate_3     (candidate_3),
        .candidate_4     (candidate_4),
        .age_1           (age_1),
        .age_2           (age_2),
        .age_3           (age_3),
        .age_4           (age_4),
        .candidate_write (candidate_write),
        .bank_selector   (bank_selector)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LW-1:0] obs,
                       input logic [LW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] pat(input logic [31:0] base);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = base + 32'(i);
        return r;
    endfunction

    function automatic logic [511:0] put(input logic [511:0] d,
                                         input int w,
                                         input logic [31:0] v);
        logic [511:0] r;
        r = d;
        r[w*32 +: 32] = v;
        return r;
    endfunction

    function automatic logic [LW-1:0] mk_line(
        input logic v, input logic d, input logic [1:0] age,
        input logic [20:0] tag, input logic [511:0] data);
        return {v, d, age, tag, data};
    endfunction

    task automatic set_ways(input logic [LW-1:0] c1, input logic [LW-1:0] c2,
                            input logic [LW-1:0] c3, input logic [LW-1:0] c4);
        candidate_1 = c1;
        candidate_2 = c2;
        candidate_3 = c3;
        candidate_4 = c4;
    endtask

    task automatic push_exp(
        input logic hit, input logic evict, input logic [31:0] ev_addr,
        input logic [511:0] ev_data, input logic [31:0] al_addr,
        input logic [3:0] bank, input logic [LW-1:0] line,
        input logic [7:0] ages, input logic [31:0] dout);
        exp_t e;
        e.hit     = hit;
        e.evict   = evict;
        e.ev_addr = ev_addr;
        e.ev_data = ev_data;
        e.al_addr = al_addr;
        e.bank    = bank;
        e.line    = line;
        e.ages    = ages;
        e.dout    = dout;
        sb.push_back(e);
    endtask

    task automatic txn(input logic [31:0] a, input logic rw,
                       input logic [31:0] d, input logic [511:0] fill);
        exp_t e;
        logic saw_ev;
        logic saw_al;
        logic done;
        e = sb.pop_front();
        cpu_req_addr   = a;
        cpu_req_rw     = rw;
        cpu_req_datain = d;
        cpu_req_enable = 1'b1;
        #1;
        chk("req_cache_en", {cache_enable, cache_rw}, 2'b10);
        tick();
        cpu_req_addr  = 32'hFFFF_FFF0;
        mem_req_ready = 1'b1;
        tick();
        cpu_req_enable = 1'b0;
        mem_req_ready  = 1'b0;
        chk("stray_ignored", dut.current_state, 3'd1);
        cache_ready = 1'b1;
        #1;
        chk("hit", dut.hit, e.hit);
        chk("miss", dut.miss, !e.hit);
        tick();
        cache_ready = 1'b0;
        saw_ev = 1'b0;
        saw_al = 1'b0;
        done   = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            case (dut.current_state)
                3'd2: begin
                    saw_ev = 1'b1;
                    chk("ev_ctl", {mem_req_enable, mem_req_rw}, 2'b11);
                    chk("ev_addr", mem_req_addr, e.ev_addr);
                    chk("ev_data", mem_req_dataout, e.ev_data);
                    mem_req_ready = 1'b1;
                    tick();
                    mem_req_ready = 1'b0;
                end
                3'd3: begin
                    saw_al = 1'b1;
                    chk("al_ctl", {mem_req_enable, mem_req_rw}, 2'b10);
                    chk("al_addr", mem_req_addr, e.al_addr);
                    mem_req_datain = fill;
                    mem_req_ready  = 1'b1;
                    tick();
                    mem_req_ready = 1'b0;
                end
                3'd4: begin
                    chk("wr_ctl", {cache_enable, cache_rw, mem_req_enable},
                        3'b110);
                    chk("bank", bank_selector, e.bank);
                    chk("line", candidate_write, e.line);
                    chk("ages", {age_4, age_3, age_2, age_1}, e.ages);
                    cache_ready = 1'b1;
                    tick();
                    cache_ready = 1'b0;
                    chk("res_pulse", {cpu_res_ready, cache_enable}, 2'b10);
                    chk("dout", cpu_res_dataout, e.dout);
                    tick();
                    chk("res_drop", {cpu_res_ready, bank_selector}, 5'b0);
                    done = 1'b1;
                end
                default: tick();
            endcase
        end
        chk("txn_done", done, 1'b1);
        chk("evict_seen", saw_ev, e.evict);
        chk("alloc_seen", saw_al, !e.hit);
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        cpu_req_addr   = '0;
        cpu_req_datain = '0;
        cpu_req_rw     = 1'b0;
        cpu_req_enable = 1'b0;
        mem_req_ready  = 1'b0;
        mem_req_datain = '0;
        cache_ready    = 1'b0;
        set_ways('0, '0, '0, '0);
        tick();
        tick();
        chk("rst_state", dut.current_state, 3'd0);
        chk("rst_ctl", {cache_enable, cache_rw, mem_req_enable,
                        mem_req_rw, cpu_res_ready, bank_selector}, 9'b0);
        chk("rst_bus", {cpu_res_dataout, mem_req_addr,
                        age_4, age_3, age_2, age_1}, 72'b0);
        chk("rst_line", candidate_write, '0);
        rst_n = 1'b1;
        tick();

        // Read hit: all ways match, way 1 wins.
        set_ways(mk_line(1, 0, 0, 21'd1, pat(32'hDEADBEEF)),
                 mk_line(1, 0, 1, 21'd1, pat(32'hDEADBEEF)),
                 mk_line(1, 0, 2, 21'd1, pat(32'hDEADBEEF)),
                 mk_line(1, 0, 3, 21'd1, pat(32'hDEADBEEF)));
        push_exp(1, 0, 0, 0, 0, 4'b0001,
                 mk_line(1, 0, 0, 21'd1, pat(32'hDEADBEEF)),
                 {2'd3, 2'd2, 2'd1, 2'd0}, 32'hDEADBEFB);
        txn(32'h0000_0ABC, 1'b0, 32'h0, '0);

        // Read miss, clean LRU victim in way 4.
        set_ways(mk_line(1, 0, 0, 21'h5, pat(32'h1000_0000)),
                 mk_line(1, 0, 1, 21'h5, pat(32'h1100_0000)),
                 mk_line(1, 0, 2, 21'h5, pat(32'h1200_0000)),
                 mk_line(1, 0, 3, 21'h5, pat(32'h1300_0000)));
        push_exp(0, 0, 0, 0, 32'h0000_0AB0, 4'b1000,
                 mk_line(1, 0, 0, 21'd1, pat(32'h5000_0000)),
                 {2'd0, 2'd3, 2'd2, 2'd1}, 32'h5000_000C);
        txn(32'h0000_0ABC, 1'b0, 32'h0, pat(32'h5000_0000));

        // Read miss, dirty LRU victim in way 1.
        set_ways(mk_line(1, 1, 3, 21'h7, pat(32'h7000_0000)),
                 mk_line(1, 0, 0, 21'h5, pat(32'h1100_0000)),
                 mk_line(1, 0, 1, 21'h5, pat(32'h1200_0000)),
                 mk_line(1, 0, 2, 21'h5, pat(32'h1300_0000)));
        push_exp(0, 1, 32'h0000_3AB0, pat(32'h7000_0000),
                 32'h0000_0AB0, 4'b0001,
                 mk_line(1, 0, 0, 21'd1, pat(32'h6000_0000)),
                 {2'd3, 2'd2, 2'd1, 2'd0}, 32'h6000_000C);
        txn(32'h0000_0ABC, 1'b0, 32'h0, pat(32'h6000_0000));

        // Write hit in way 3, last word; read data must hold.
        set_ways(mk_line(1, 0, 0, 21'h5, pat(32'h1000_0000)),
                 mk_line(1, 0, 1, 21'h5, pat(32'h1100_0000)),
                 mk_line(1, 0, 2, 21'd1, pat(32'hA000_0000)),
                 mk_line(1, 0, 3, 21'h5, pat(32'h1300_0000)));
        push_exp(1, 0, 0, 0, 0, 4'b0100,
                 mk_line(1, 1, 0, 21'd1,
                         put(pat(32'hA000_0000), 15, 32'hCAFEBABE)),
                 {2'd3, 2'd0, 2'd2, 2'd1}, 32'h6000_000C);
        txn(32'h0000_0ABF, 1'b1, 32'hCAFEBABE, '0);

        // Write miss: invalid way 1 preferred over dirty LRU way 4.
        set_ways(mk_line(0, 0, 1, 21'h0, pat(32'h2000_0000)),
                 mk_line(1, 0, 0, 21'h5, pat(32'h1100_0000)),
                 mk_line(1, 0, 2, 21'h5, pat(32'h1200_0000)),
                 mk_line(1, 1, 3, 21'h5, pat(32'h1300_0000)));
        push_exp(0, 0, 0, 0, 32'h0000_0AB0, 4'b0001,
                 mk_line(1, 1, 0, 21'd1,
                         put(pat(32'h9000_0000), 13, 32'hFACECAFE)),
                 {2'd3, 2'd3, 2'd1, 2'd0}, 32'h6000_000C);
        txn(32'h0000_0ABD, 1'b1, 32'hFACECAFE, pat(32'h9000_0000));

        // Asynchronous reset while waiting in ALLOCATE.
        set_ways(mk_line(1, 0, 0, 21'h5, pat(32'h1000_0000)),
                 mk_line(1, 0, 1, 21'h5, pat(32'h1100_0000)),
                 mk_line(1, 0, 2, 21'h5, pat(32'h1200_0000)),
                 mk_line(1, 0, 3, 21'h5, pat(32'h1300_0000)));
        cpu_req_addr   = 32'h0000_0ABC;
        cpu_req_rw     = 1'b0;
        cpu_req_enable = 1'b1;
        tick();
        cpu_req_enable = 1'b0;
        cache_ready    = 1'b1;
        tick();
        cache_ready = 1'b0;
        chk("alloc_before_rst", {dut.current_state, mem_req_enable},
            4'b0111);
        rst_n = 1'b0;
        #1;
        chk("arst_state", dut.current_state, 3'd0);
        chk("arst_ctl", {cache_enable, mem_req_enable, cpu_res_ready,
                         mem_req_rw, cache_rw}, 5'b0);
        chk("arst_bus", {mem_req_addr, cpu_res_dataout}, 64'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", dut.current_state, 3'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
